// File: rtl/multi_project_io_mux.sv
// Pad-bus owner for a multi-project harness: one Wishbone-selected project drives the pads,
// with a break-before-make switch sequence and a programmable all-inputs guard interval.
module multi_project_io_mux #(
    parameter int          NUM_PROJECTS = 8,
    parameter int          IO_WIDTH     = 38,
    parameter int          GUARD_RESET  = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             wbs_stb_i,
    input  logic                             wbs_cyc_i,
    input  logic                             wbs_we_i,
    input  logic [3:0]                       wbs_sel_i,
    input  logic [31:0]                      wbs_adr_i,
    input  logic [31:0]                      wbs_dat_i,
    output logic                             wbs_ack_o,
    output logic [31:0]                      wbs_dat_o,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_out,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_oeb,
    output logic [NUM_PROJECTS-1:0]          active,
    output logic [IO_WIDTH-1:0]              io_out,
    output logic [IO_WIDTH-1:0]              io_oeb,
    output logic                             switch_irq
);

    localparam logic [7:0] IDX_NONE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GUARD  = 2'd2,
        ST_ENABLE = 2'd3
    } state_t;

    state_t                    state_r, state_s;
    logic [7:0]                guard_cnt_r;
    logic [7:0]                cur_idx_r, req_idx_r, next_idx_s;
    logic [7:0]                guard_r, count_r;
    logic                      err_r, ack_r, irq_r;
    logic [31:0]               dat_r, rd_s;
    logic [NUM_PROJECTS-1:0]   active_r;
    logic [IO_WIDTH-1:0]       io_out_r, io_oeb_r, pad_out_s, pad_oeb_s;
    logic                      hit_s, req_s, wr_s, sel_wr_s, accept_s, reject_s;
    logic                      err_clr_s, guard_wr_s, busy_s, drive_s;
    logic                      unused_s;

    // 0xFF means "no project"; anything else must name an existing slot.
    function automatic logic idx_valid(input logic [7:0] idx);
        return ({1'b0, idx} < 9'(NUM_PROJECTS)) || (idx == IDX_NONE);
    endfunction

    function automatic logic [NUM_PROJECTS-1:0] onehot(input logic [7:0] idx);
        logic [NUM_PROJECTS-1:0] v;
        for (int k = 0; k < NUM_PROJECTS; k++) begin
            v[k] = (idx == k[7:0]);
        end
        return v;
    endfunction

    assign unused_s = &{1'b0, wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:8]};

    // Bus decode; ack_r blocks re-sampling the request held during its own ack cycle.
    always_comb begin
        hit_s      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        req_s      = wbs_stb_i & wbs_cyc_i & hit_s & ~ack_r;
        wr_s       = req_s & wbs_we_i;
        sel_wr_s   = wr_s & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0];
        accept_s   = sel_wr_s & (state_r == ST_IDLE) & idx_valid(wbs_dat_i[7:0]);
        reject_s   = sel_wr_s & ~accept_s;
        err_clr_s  = wr_s & (wbs_adr_i[3:2] == 2'd1) & wbs_sel_i[0] & wbs_dat_i[1];
        guard_wr_s = wr_s & (wbs_adr_i[3:2] == 2'd2) & wbs_sel_i[0];
        busy_s     = (state_r == ST_DRAIN) || (state_r == ST_GUARD);
    end

    // Switch sequencer next state and the index that will be current after this edge.
    always_comb begin
        state_s    = state_r;
        next_idx_s = cur_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_DRAIN;
                else          state_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (guard_r == 8'd0) state_s = ST_ENABLE;
                else                 state_s = ST_GUARD;
            end
            ST_GUARD: begin
                if (guard_cnt_r == 8'd0) state_s = ST_ENABLE;
                else                     state_s = ST_GUARD;
            end
            ST_ENABLE: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
        if (state_s == ST_ENABLE) next_idx_s = req_idx_r;
        else                      next_idx_s = cur_idx_r;
    end

    // Pads follow the selected slot only outside the drain/guard window.
    always_comb begin
        pad_out_s = {IO_WIDTH{1'b0}};
        pad_oeb_s = {IO_WIDTH{1'b1}};
        drive_s   = ((state_s == ST_IDLE) || (state_s == ST_ENABLE)) && (next_idx_s != IDX_NONE);
        for (int k = 0; k < NUM_PROJECTS; k++) begin
            if (drive_s && (next_idx_s == k[7:0])) begin
                pad_out_s = proj_io_out[k*IO_WIDTH +: IO_WIDTH];
                pad_oeb_s = proj_io_oeb[k*IO_WIDTH +: IO_WIDTH];
            end else begin
                pad_out_s = pad_out_s;
                pad_oeb_s = pad_oeb_s;
            end
        end
    end

    // Register read mux.
    always_comb begin
        rd_s = 32'd0;
        case (wbs_adr_i[3:2])
            2'd0:    rd_s = {busy_s, 23'd0, cur_idx_r};
            2'd1:    rd_s = {16'd0, count_r, 6'd0, err_r, busy_s};
            2'd2:    rd_s = {24'd0, guard_r};
            2'd3:    rd_s = 32'd0;
            default: rd_s = 32'd0;
        endcase
    end

    // Sequencer state and guard countdown (loaded with GUARD-1 on leaving DRAIN).
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            guard_cnt_r <= 8'd0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_DRAIN)      guard_cnt_r <= guard_r - 8'd1;
            else if (state_r == ST_GUARD) guard_cnt_r <= guard_cnt_r - 8'd1;
        end
    end

    // Control/status registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cur_idx_r <= IDX_NONE;
            req_idx_r <= IDX_NONE;
            guard_r   <= 8'(GUARD_RESET);
            err_r     <= 1'b0;
            count_r   <= 8'd0;
        end else begin
            cur_idx_r <= next_idx_s;
            if (accept_s)   req_idx_r <= wbs_dat_i[7:0];
            if (guard_wr_s) guard_r   <= wbs_dat_i[7:0];
            if (reject_s)       err_r <= 1'b1;
            else if (err_clr_s) err_r <= 1'b0;
            if (state_s == ST_ENABLE) count_r <= count_r + 8'd1;
        end
    end

    // Registered bus, enable, pad and interrupt outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_r    <= 1'b0;
            dat_r    <= 32'd0;
            active_r <= {NUM_PROJECTS{1'b0}};
            io_out_r <= {IO_WIDTH{1'b0}};
            io_oeb_r <= {IO_WIDTH{1'b1}};
            irq_r    <= 1'b0;
        end else begin
            ack_r    <= req_s;
            dat_r    <= (req_s && !wbs_we_i) ? rd_s : 32'd0;
            active_r <= drive_s ? onehot(next_idx_s) : {NUM_PROJECTS{1'b0}};
            io_out_r <= pad_out_s;
            io_oeb_r <= pad_oeb_s;
            irq_r    <= (state_s == ST_ENABLE);
        end
    end

    assign wbs_ack_o  = ack_r;
    assign wbs_dat_o  = dat_r;
    assign active     = active_r;
    assign io_out     = io_out_r;
    assign io_oeb     = io_oeb_r;
    assign switch_irq = irq_r;

endmodule

// File: tb/tb_multi_project_io_mux.sv
// Directed bench for multi_project_io_mux: register access, switch timing, guard,
// error handling and reset during a switch.
module tb_multi_project_io_mux;

    localparam int NP = 8;
    localparam int IW = 38;
    localparam logic [IW-1:0] ALL1 = {IW{1'b1}};

    logic             clk;
    logic             rst;
    logic             stb, cyc, we;
    logic [3:0]       sel;
    logic [31:0]      adr, wdat;
    logic             ack;
    logic [31:0]      rdat;
    logic [NP*IW-1:0] p_out, p_oeb;
    logic [NP-1:0]    active;
    logic [IW-1:0]    io_out, io_oeb;
    logic             irq;

    int n_cmp = 0;
    int n_err = 0;

    multi_project_io_mux dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .proj_io_out(p_out), .proj_io_oeb(p_oeb),
        .active(active), .io_out(io_out), .io_oeb(io_oeb), .switch_irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [IW-1:0] slot_out(input int k);
        return 38'h15_0000_0000 ^ (38'(k) * 38'h01_0101_0101);
    endfunction

    function automatic logic [IW-1:0] slot_oeb(input int k);
        return 38'h3F_0000_0F00 ^ 38'(k);
    endfunction

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got = 1'b0;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1'b1; break; end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL wb_write_ack adr=%h: no ack within 4 cycles", a);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bit got = 1'b0;
        d = 32'hDEAD_BEEF;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1'b1; d = rdat; break; end
        end
        stb = 1'b0; cyc = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL wb_read_ack adr=%h: no ack within 4 cycles", a);
        end
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        n_cmp++;
        if (d !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, d, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (active !== 8'h00 || io_oeb !== ALL1 || io_out !== 38'd0 || ack !== 1'b0 ||
            rdat !== 32'd0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: active=%h oeb=%h out=%h ack=%b dat=%h irq=%b expected 00/3fffffffff/0/0/0/0",
                     active, io_oeb, io_out, ack, rdat, irq);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check_reg("reset_sel", 32'h3000_0000, 32'h0000_00FF);
        check_reg("reset_guard", 32'h3000_0008, 32'h0000_0010);
        check_reg("reset_status", 32'h3000_0004, 32'h0000_0000);
    endtask

    task automatic test_unmapped();
        int acks = 0;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        stb = 1'b0; cyc = 1'b0;
        n_cmp++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL unmapped_ack: got %0d acks expected 0", acks);
        end
        wb_write(32'h3000_000C, 32'hFFFF_FFFF, 4'hF);
        check_reg("reg_c_zero", 32'h3000_000C, 32'h0000_0000);
    endtask

    task automatic test_select3();
        int irqs = 0;
        wb_write(32'h3000_0000, 32'h0000_0003, 4'h1);
        for (int i = 1; i <= 19; i++) begin
            logic [NP-1:0] ea;
            logic [IW-1:0] eo, ee;
            ea = (i >= 18) ? 8'h08 : 8'h00;
            eo = (i >= 18) ? slot_out(3) : 38'd0;
            ee = (i >= 18) ? slot_oeb(3) : ALL1;
            if (irq) irqs++;
            n_cmp++;
            if (active !== ea || io_out !== eo || io_oeb !== ee || irq !== (i == 18)) begin
                n_err++;
                $display("FAIL sel3_cycle%0d: active=%h out=%h oeb=%h irq=%b expected %h/%h/%h/%b",
                         i, active, io_out, io_oeb, irq, ea, eo, ee, (i == 18));
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (irqs != 1) begin
            n_err++;
            $display("FAIL sel3_irq_pulses: got %0d expected 1", irqs);
        end
        check_reg("sel3_status", 32'h3000_0004, 32'h0000_0100);
        check_reg("sel3_sel", 32'h3000_0000, 32'h0000_0003);
        p_out[3*IW +: IW] = 38'h2A_AAAA_AAAA;
        n_cmp++;
        if (io_out !== slot_out(3)) begin
            n_err++;
            $display("FAIL lag_old: got %h expected %h", io_out, slot_out(3));
        end
        @(posedge clk); #1;
        n_cmp++;
        if (io_out !== 38'h2A_AAAA_AAAA) begin
            n_err++;
            $display("FAIL lag_new: got %h expected 2aaaaaaaaa", io_out);
        end
    endtask

    task automatic test_switch_g0();
        wb_write(32'h3000_0008, 32'h0000_0000, 4'h1);
        n_cmp++;
        if (active !== 8'h08 || io_oeb !== slot_oeb(3)) begin
            n_err++;
            $display("FAIL g0_before: active=%h oeb=%h expected 08/%h", active, io_oeb, slot_oeb(3));
        end
        wb_write(32'h3000_0000, 32'h0000_0005, 4'h1);
        n_cmp++;
        if (active !== 8'h00 || io_oeb !== ALL1 || io_out !== 38'd0) begin
            n_err++;
            $display("FAIL g0_drain: active=%h oeb=%h out=%h expected 00/3fffffffff/0", active, io_oeb, io_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (active !== 8'h20 || io_out !== slot_out(5) || io_oeb !== slot_oeb(5) || irq !== 1'b1) begin
            n_err++;
            $display("FAIL g0_enable: active=%h out=%h oeb=%h irq=%b expected 20/%h/%h/1",
                     active, io_out, io_oeb, irq, slot_out(5), slot_oeb(5));
        end
    endtask

    task automatic test_invalid();
        wb_write(32'h3000_0000, 32'h0000_0009, 4'h1);
        check_reg("inv_status", 32'h3000_0004, 32'h0000_0202);
        check_reg("inv_sel", 32'h3000_0000, 32'h0000_0005);
        n_cmp++;
        if (active !== 8'h20) begin
            n_err++;
            $display("FAIL inv_active: got %h expected 20", active);
        end
        wb_write(32'h3000_0004, 32'h0000_0002, 4'h1);
        check_reg("inv_clear", 32'h3000_0004, 32'h0000_0200);
        wb_write(32'h3000_0000, 32'h0000_0003, 4'hE);
        check_reg("nobyte0_sel", 32'h3000_0000, 32'h0000_0005);
        check_reg("nobyte0_status", 32'h3000_0004, 32'h0000_0200);
    endtask

    task automatic test_write_during_guard();
        bit done = 1'b0;
        wb_write(32'h3000_0008, 32'h0000_0004, 4'h1);
        wb_write(32'h3000_0000, 32'h0000_0002, 4'h1);
        check_reg("busy_sel", 32'h3000_0000, 32'h8000_0005);
        wb_write(32'h3000_0000, 32'h0000_0006, 4'h1);
        for (int i = 0; i < 20; i++) begin
            if (active !== 8'h00) begin done = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!done || active !== 8'h04 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL guard_write_complete: active=%h irq=%b done=%b expected 04/1/1", active, irq, done);
        end
        check_reg("guard_write_status", 32'h3000_0004, 32'h0000_0302);
        check_reg("guard_write_sel", 32'h3000_0000, 32'h0000_0002);
    endtask

    task automatic test_reset_mid();
        int irqs = 0;
        wb_write(32'h3000_0008, 32'h0000_0010, 4'h1);
        wb_write(32'h3000_0000, 32'h0000_0001, 4'h1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (active !== 8'h00 || io_oeb !== ALL1 || io_out !== 38'd0 || irq !== 1'b0 || ack !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: active=%h oeb=%h out=%h irq=%b ack=%b expected 00/3fffffffff/0/0/0",
                     active, io_oeb, io_out, irq, ack);
        end
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (irq || active !== 8'h00) irqs++;
        end
        n_cmp++;
        if (irqs != 0) begin
            n_err++;
            $display("FAIL mid_reset_quiet: got %0d irq/active cycles expected 0", irqs);
        end
        check_reg("mid_reset_status", 32'h3000_0004, 32'h0000_0000);
        check_reg("mid_reset_sel", 32'h3000_0000, 32'h0000_00FF);
        check_reg("mid_reset_guard", 32'h3000_0008, 32'h0000_0010);
    endtask

    initial begin
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0; rst = 1'b1;
        for (int k = 0; k < NP; k++) begin
            p_out[k*IW +: IW] = slot_out(k);
            p_oeb[k*IW +: IW] = slot_oeb(k);
        end
        test_reset();
        test_unmapped();
        test_select3();
        test_switch_g0();
        test_invalid();
        test_write_during_guard();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_project_io_mux.md
# multi_project_io_mux

Parametrised successor to the flat multi-project wrapper. Instead of each project tristating shared pads from its own LA `active` bit, it owns the pad bus. It holds a Wishbone-programmable selection of exactly one of `NUM_PROJECTS` projects, drives that project's `active` line, and registers its `io_out`/`io_oeb` onto the Caravel pads. Project changes run a break-before-make sequence with a programmable all-inputs guard interval, so two projects never drive the pads in the same cycle.

## Interface
Parameters:
- `NUM_PROJECTS`, 8: number of project slots, 1..255
- `IO_WIDTH`, 38: pad bits per project (`MPRJ_IO_PADS`)
- `GUARD_RESET`, 16: reset value of GUARD register, 0..255
- `BASE_ADDR`, 32'h3000_0000: Wishbone base; 16-byte window

Ports:
- `wb_clk_i`  in  1  sole clock
- `wb_rst_i`  in  1  synchronous, active-high reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe/cycle/write
- `wbs_sel_i`  in  4  byte enables
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address, write data
- `wbs_ack_o`  out  1  single-cycle ack
- `wbs_dat_o`  out  32  read data
- `proj_io_out`  in  NUM_PROJECTS*IO_WIDTH  packed project outputs, slot k at `[k*IO_WIDTH +: IO_WIDTH]`
- `proj_io_oeb`  in  NUM_PROJECTS*IO_WIDTH  packed project output enables, same packing
- `active`  out  NUM_PROJECTS  one-hot-or-zero project enable
- `io_out`  out  IO_WIDTH  registered pad outputs
- `io_oeb`  out  IO_WIDTH  registered pad enables (1 = input)
- `switch_irq`  out  1  one-cycle pulse on switch completion

## Operation
- **Address decode:** a transaction is decoded when `wbs_adr_i[31:4] == BASE_ADDR[31:4]`, using `adr[3:2]`. Other addresses get no ack.
- **Register 0x0, SEL:**
  - Write byte 0 (`sel[0]`) = requested index. 0xFF = no project.
  - Read: `[7:0]` current index (0xFF if none), `[31]` busy.
- **Register 0x4, STATUS:**
  - `[0]` busy (RO).
  - `[1]` err (sticky). Writing 1 to bit 1 clears it.
  - `[15:8]` switch count, wraps 255→0.
- **Register 0x8, GUARD:** `[7:0]` guard cycles, RW.
- **Register 0xC:** reads 0, writes ignored.
- **Request handling:**
  - A SEL write with index < NUM_PROJECTS or 0xFF, while IDLE, starts a switch. Writing the current index still runs the full sequence, which re-initialises that project.
  - Other indices set err; no state change.
  - A SEL write while busy is acked, ignored, and sets err.
- **FSM:**
  - IDLE → DRAIN on accepted request.
  - DRAIN (1 cycle): `active` = 0, pads forced to input.
  - GUARD: held for GUARD cycles; skipped if GUARD = 0.
  - ENABLE (1 cycle): current index ← request. `active[idx]` = 1 (none for 0xFF), count += 1, `switch_irq` = 1.
  - → IDLE.
- **Pad mux:**
  - In IDLE/ENABLE with a valid index, `io_out`/`io_oeb` are registered copies of that slot.
  - In DRAIN/GUARD, or with index 0xFF: `io_oeb` = all 1, `io_out` = 0.
- **Reset:** state IDLE, index 0xFF, GUARD = GUARD_RESET, err = 0, count = 0. Outputs: `active` = 0, `io_oeb` all 1, `io_out` = 0, `wbs_ack_o` = 0, `wbs_dat_o` = 0, `switch_irq` = 0.
- **Reset mid-switch:** returns to reset state at the next edge; no irq.

## Timing
- **Wishbone:** with `stb&cyc` sampled at edge t, ack = 1 for cycle t+1 only. Read data is valid with ack. Back-to-back requests are acked every other cycle at most; `stb` is held by the master until ack.
- **SEL write accepted at edge t:**
  - From t+1: DRAIN, busy = 1, `active` = 0, pad force.
  - For G = GUARD ≥ 1: GUARD occupies t+2 … t+1+G.
  - ENABLE at t+2+G: `active` asserted, `switch_irq` high, busy cleared, count incremented.
  - Pads show the new project's values, registered from the prior cycle's `proj_*`, from t+2+G.
  - Total switch latency 2+G cycles.
- **Pad path in IDLE:** one-cycle latency from `proj_io_*` to `io_*`.
- **Simultaneous events:** a write in the same cycle as ENABLE sees busy (ignored + err). A SEL write with `sel[0]` = 0 is acked and changes nothing.

## Test plan
- **Reset:** check `active` = 0, `io_oeb` = 0x3F_FFFF_FFFF, SEL reads 0x0000_00FF, GUARD reads 16.
- **Select project 3, GUARD = 16:** `active` = 0x08 exactly 18 cycles after the write edge. `io_oeb` all 1 in between, then tracks slot 3 with 1-cycle lag. `switch_irq` is one pulse; count = 1.
- **Switch 3→5 with GUARD = 0:** `active` goes 0x08 → 0x00 for 1 cycle → 0x20. Pads are never driven from slot 3 and slot 5 in adjacent cycles without an input-only cycle between.
- **Invalid index 9 with NUM_PROJECTS = 8:** err = 1, index unchanged. Write STATUS 0x2 → err = 0.
- **SEL write during GUARD:** acked, ignored, err set; the original switch completes.
- **Reset asserted during GUARD:** next cycle matches the reset state, no `switch_irq`, count = 0.
